// File: rtl/io_pkg.sv
// Shared defaults and helpers for the I/O flag unit: character width, FIFO
// depth defaults, pointer-width function and the IEN/R next-state op codes.
package io_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int IN_DEPTH_DEF  = 4;
  localparam int OUT_DEPTH_DEF = 4;

  // Next-state actions for the IEN and R flip-flops. The priority between
  // them is resolved in io_flag_unit (clear always beats set).
  localparam logic [1:0] FLAG_HOLD = 2'b00;
  localparam logic [1:0] FLAG_SET  = 2'b01;
  localparam logic [1:0] FLAG_CLR  = 2'b10;

  // Pointer width for a power-of-two FIFO; a depth of 1 still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with a registered head. The head register only changes
// when the FIFO will be non-empty, so an emptied FIFO keeps showing the last
// entry it delivered (zero after reset). Push while full and pop while empty
// are ignored, so callers may connect raw request strobes.
module io_sync_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int DEPTH = IN_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [WIDTH-1:0]          head,
  output logic [ptr_w(DEPTH):0]     count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = head_q;
  assign count   = cnt;

  // Next read pointer, occupancy and head value; a write landing in the slot
  // that becomes the head is forwarded because memory is not yet updated.
  always_comb begin
    rd_ptr_nxt = pop_ok ? rd_ptr + PW'(1) : rd_ptr;
    cnt_nxt    = cnt + CW'(push_ok) - CW'(pop_ok);
    head_nxt   = head_q;
    if (cnt_nxt != '0) begin
      if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
        head_nxt = wdata;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Pointers, occupancy and visible head; pointers wrap at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      head_q <= head_nxt;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_flag_unit.sv
// Keyboard/display I/O block: input FIFO behind INPR/FGI, output FIFO behind
// OUTR/FGO, plus the IEN and interrupt-request (R) flip-flops.
// Optional macro IO_ERR_EN adds sticky overflow flags in_ovf/out_ovf and an
// err_clr input; without it, dropped bytes are silent.
module io_flag_unit
  import io_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int IN_DEPTH  = IN_DEPTH_DEF,
  parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kbd_valid,
  input  logic [DATA_W-1:0] kbd_data,
  output logic              kbd_ready,
  output logic [DATA_W-1:0] inpr_outdata,
  output logic              fgi_outdata,
  input  logic              inp_ack,
  input  logic              out_load,
  input  logic [DATA_W-1:0] out_indata,
  output logic              fgo_outdata,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              disp_ready,
  input  logic              ion,
  input  logic              iof,
  output logic              ien_outdata,
  input  logic              instr_boundary,
  input  logic              int_ack,
`ifdef IO_ERR_EN
  input  logic              err_clr,
  output logic              in_ovf,
  output logic              out_ovf,
`endif
  output logic              r_outdata
);

  logic                     in_full;
  logic                     in_empty;
  logic [ptr_w(IN_DEPTH):0] in_count;
  logic                     out_full;
  logic                     out_empty;
  logic [ptr_w(OUT_DEPTH):0] out_count;
  logic                     ien_q;
  logic                     r_q;
  logic [1:0]               ien_op;
  logic [1:0]               r_op;
  logic                     unused_counts;

  io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (kbd_valid),
    .wdata (kbd_data),
    .pop   (inp_ack),
    .full  (in_full),
    .empty (in_empty),
    .head  (inpr_outdata),
    .count (in_count)
  );

  io_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_load),
    .wdata (out_indata),
    .pop   (disp_ready),
    .full  (out_full),
    .empty (out_empty),
    .head  (disp_data),
    .count (out_count)
  );

  // Occupancy is not needed at this level; fold it into a named sink.
  assign unused_counts = ^{in_count, out_count};

  assign kbd_ready   = !in_full;
  assign fgi_outdata = !in_empty;
  assign fgo_outdata = !out_full;
  assign disp_valid  = !out_empty;
  assign ien_outdata = ien_q;
  assign r_outdata   = r_q;

  // Priority-resolve the IEN and R actions; int_ack clears both above any set.
  always_comb begin
    ien_op = FLAG_HOLD;
    r_op   = FLAG_HOLD;
    if (int_ack) begin
      ien_op = FLAG_CLR;
    end else if (iof) begin
      ien_op = FLAG_CLR;
    end else if (ion) begin
      ien_op = FLAG_SET;
    end
    if (int_ack) begin
      r_op = FLAG_CLR;
    end else if (instr_boundary && ien_q && (fgi_outdata || fgo_outdata)) begin
      r_op = FLAG_SET;
    end
  end

  // IEN and R registers; R stays set until acknowledged even if flags drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ien_q <= 1'b0;
      r_q   <= 1'b0;
    end else begin
      case (ien_op)
        FLAG_SET: ien_q <= 1'b1;
        FLAG_CLR: ien_q <= 1'b0;
        default:  ien_q <= ien_q;
      endcase
      case (r_op)
        FLAG_SET: r_q <= 1'b1;
        FLAG_CLR: r_q <= 1'b0;
        default:  r_q <= r_q;
      endcase
    end
  end

`ifdef IO_ERR_EN
  // Sticky overflow flags; a new overflow in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ovf  <= 1'b0;
      out_ovf <= 1'b0;
    end else begin
      if (kbd_valid && in_full) begin
        in_ovf <= 1'b1;
      end else if (err_clr) begin
        in_ovf <= 1'b0;
      end
      if (out_load && out_full) begin
        out_ovf <= 1'b1;
      end else if (err_clr) begin
        out_ovf <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_flag_unit.sv
// Self-checking bench for io_flag_unit: directed scenarios plus randomized
// traffic, all compared against a queue-based behavioural model.
module tb_io_flag_unit;

  localparam int DW = 8;
  localparam int ID = 4;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          kbd_valid;
  logic [DW-1:0] kbd_data;
  logic          kbd_ready;
  logic [DW-1:0] inpr_outdata;
  logic          fgi_outdata;
  logic          inp_ack;
  logic          out_load;
  logic [DW-1:0] out_indata;
  logic          fgo_outdata;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          disp_ready;
  logic          ion;
  logic          iof;
  logic          ien_outdata;
  logic          instr_boundary;
  logic          int_ack;
  logic          r_outdata;
`ifdef IO_ERR_EN
  logic          err_clr;
  logic          in_ovf;
  logic          out_ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  logic [DW-1:0] m_inpr;
  logic [DW-1:0] m_disp;
  logic          m_ien;
  logic          m_r;
  logic          m_in_ovf;
  logic          m_out_ovf;

  always #5 clk = ~clk;

  io_flag_unit #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk            (clk),
    .reset          (reset),
    .kbd_valid      (kbd_valid),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .inpr_outdata   (inpr_outdata),
    .fgi_outdata    (fgi_outdata),
    .inp_ack        (inp_ack),
    .out_load       (out_load),
    .out_indata     (out_indata),
    .fgo_outdata    (fgo_outdata),
    .disp_valid     (disp_valid),
    .disp_data      (disp_data),
    .disp_ready     (disp_ready),
    .ion            (ion),
    .iof            (iof),
    .ien_outdata    (ien_outdata),
    .instr_boundary (instr_boundary),
    .int_ack        (int_ack),
`ifdef IO_ERR_EN
    .err_clr        (err_clr),
    .in_ovf         (in_ovf),
    .out_ovf        (out_ovf),
`endif
    .r_outdata      (r_outdata)
  );

  // Packed view of every DUT output: ready,fgi,inpr,fgo,dvalid,ddata,ien,r,iovf,oovf
  function automatic logic [23:0] dut_vec();
`ifdef IO_ERR_EN
    return {kbd_ready, fgi_outdata, inpr_outdata, fgo_outdata, disp_valid,
            disp_data, ien_outdata, r_outdata, in_ovf, out_ovf};
`else
    return {kbd_ready, fgi_outdata, inpr_outdata, fgo_outdata, disp_valid,
            disp_data, ien_outdata, r_outdata, 2'b00};
`endif
  endfunction

  function automatic logic [23:0] model_vec();
    logic ovf_i;
    logic ovf_o;
`ifdef IO_ERR_EN
    ovf_i = m_in_ovf;
    ovf_o = m_out_ovf;
`else
    ovf_i = 1'b0;
    ovf_o = 1'b0;
`endif
    return {(in_q.size() < ID), (in_q.size() != 0), m_inpr,
            (out_q.size() < OD), (out_q.size() != 0), m_disp,
            m_ien, m_r, ovf_i, ovf_o};
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic clr;
    logic fgi_o;
    logic fgo_o;
    if (reset) begin
      in_q.delete();
      out_q.delete();
      m_inpr = '0; m_disp = '0; m_ien = 1'b0; m_r = 1'b0;
      m_in_ovf = 1'b0; m_out_ovf = 1'b0;
      return;
    end
`ifdef IO_ERR_EN
    clr = err_clr;
`else
    clr = 1'b0;
`endif
    fgi_o = (in_q.size() != 0);
    fgo_o = (out_q.size() < OD);
    if (kbd_valid && in_q.size() == ID) m_in_ovf = 1'b1;
    else if (clr) m_in_ovf = 1'b0;
    if (out_load && out_q.size() == OD) m_out_ovf = 1'b1;
    else if (clr) m_out_ovf = 1'b0;
    if (int_ack) m_r = 1'b0;
    else if (instr_boundary && m_ien && (fgi_o || fgo_o)) m_r = 1'b1;
    if (int_ack || iof) m_ien = 1'b0;
    else if (ion) m_ien = 1'b1;
    begin
      bit pop_i, push_i, pop_o, push_o;
      pop_i  = inp_ack && in_q.size() > 0;
      push_i = kbd_valid && in_q.size() < ID;
      push_o = out_load && out_q.size() < OD;
      pop_o  = disp_ready && out_q.size() > 0;
      if (pop_i) void'(in_q.pop_front());
      if (push_i) in_q.push_back(kbd_data);
      if (pop_o) void'(out_q.pop_front());
      if (push_o) out_q.push_back(out_indata);
    end
    if (in_q.size() != 0) m_inpr = in_q[0];
    if (out_q.size() != 0) m_disp = out_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; kbd_valid = 1'b0; kbd_data = '0; inp_ack = 1'b0;
    out_load = 1'b0; out_indata = '0; disp_ready = 1'b0; ion = 1'b0;
    iof = 1'b0; instr_boundary = 1'b0; int_ack = 1'b0;
`ifdef IO_ERR_EN
    err_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [23:0] exp_v;
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_v = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    vectors++;
    if (dut_vec() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_state got %h expected %h", dut_vec(), exp_v);
    end
  endtask

  task automatic test_input_fifo();
    logic [9:0] exp_f;
    for (int i = 0; i < 5; i++) begin
      kbd_valid = 1'b1;
      kbd_data  = 8'(8'h41 + i);
      tick();
      exp_f = {((i < 3) ? 1'b1 : 1'b0), 1'b1, 8'h41};
      vectors++;
      if ({kbd_ready, fgi_outdata, inpr_outdata} !== exp_f) begin
        miscompares++;
        $display("FAIL in_fill_%0d got %h expected %h", i, {kbd_ready, fgi_outdata, inpr_outdata}, exp_f);
      end
`ifdef IO_ERR_EN
      vectors++;
      if (in_ovf !== ((i == 4) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL in_ovf_%0d got %b", i, in_ovf);
      end
`endif
    end
    kbd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inp_ack = 1'b1;
      tick();
      exp_f = {1'b1, ((i < 3) ? 1'b1 : 1'b0), ((i < 3) ? 8'(8'h42 + i) : 8'h44)};
      vectors++;
      if ({kbd_ready, fgi_outdata, inpr_outdata} !== exp_f) begin
        miscompares++;
        $display("FAIL in_drain_%0d got %h expected %h", i, {kbd_ready, fgi_outdata, inpr_outdata}, exp_f);
      end
    end
    inp_ack = 1'b0;
`ifdef IO_ERR_EN
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (in_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL in_ovf_clear got %b expected 0", in_ovf);
    end
`endif
  endtask

  task automatic test_output_fifo();
    logic [9:0] exp_f;
    disp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_load   = 1'b1;
      out_indata = 8'(8'h30 + i);
      tick();
      exp_f = {((i < 3) ? 1'b1 : 1'b0), 1'b1, 8'h30};
      vectors++;
      if ({fgo_outdata, disp_valid, disp_data} !== exp_f) begin
        miscompares++;
        $display("FAIL out_fill_%0d got %h expected %h", i, {fgo_outdata, disp_valid, disp_data}, exp_f);
      end
    end
    out_load = 1'b0;
    disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({disp_valid, disp_data} !== {1'b1, 8'(8'h30 + i)}) begin
        miscompares++;
        $display("FAIL out_drain_%0d got %h expected %h", i, {disp_valid, disp_data}, {1'b1, 8'(8'h30 + i)});
      end
      tick();
    end
    disp_ready = 1'b0;
    vectors++;
    if ({fgo_outdata, disp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL out_empty got %b expected 10", {fgo_outdata, disp_valid});
    end
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL out_model got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_interrupt();
    ion = 1'b1;
    tick();
    ion = 1'b0;
    kbd_valid = 1'b1;
    kbd_data  = 8'h55;
    tick();
    kbd_valid = 1'b0;
    vectors++;
    if ({ien_outdata, fgi_outdata, r_outdata} !== 3'b110) begin
      miscompares++;
      $display("FAIL int_armed got %b expected 110", {ien_outdata, fgi_outdata, r_outdata});
    end
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    vectors++;
    if (r_outdata !== 1'b1) begin
      miscompares++;
      $display("FAIL int_r_set got %b expected 1", r_outdata);
    end
    inp_ack = 1'b1;
    tick();
    inp_ack = 1'b0;
    vectors++;
    if ({fgi_outdata, r_outdata} !== 2'b01) begin
      miscompares++;
      $display("FAIL int_r_hold got %b expected 01", {fgi_outdata, r_outdata});
    end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    vectors++;
    if ({ien_outdata, r_outdata} !== 2'b00) begin
      miscompares++;
      $display("FAIL int_ack_clear got %b expected 00", {ien_outdata, r_outdata});
    end
  endtask

  task automatic test_ien_priority();
    ion = 1'b1;
    tick();
    iof = 1'b1;
    tick();
    vectors++;
    if (ien_outdata !== 1'b0) begin
      miscompares++;
      $display("FAIL ien_iof_over_ion got %b expected 0", ien_outdata);
    end
    iof = 1'b0;
    tick();
    vectors++;
    if (ien_outdata !== 1'b1) begin
      miscompares++;
      $display("FAIL ien_set got %b expected 1", ien_outdata);
    end
    ion = 1'b0;
    instr_boundary = 1'b1;
    int_ack = 1'b1;
    tick();
    instr_boundary = 1'b0;
    int_ack = 1'b0;
    vectors++;
    if ({ien_outdata, r_outdata} !== 2'b00) begin
      miscompares++;
      $display("FAIL ack_over_set got %b expected 00", {ien_outdata, r_outdata});
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] exp_v;
    ion = 1'b1;
    for (int i = 0; i < 2; i++) begin
      kbd_valid = 1'b1; kbd_data = 8'(8'h60 + i);
      out_load = 1'b1; out_indata = 8'(8'h70 + i);
      tick();
    end
    ion = 1'b0;
    kbd_valid = 1'b0; out_load = 1'b0;
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL half_full got %h expected %h", dut_vec(), model_vec());
    end
    reset = 1'b1; kbd_valid = 1'b1; out_load = 1'b1; ion = 1'b1; instr_boundary = 1'b1;
    tick();
    idle_inputs();
    exp_v = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00};
    vectors++;
    if (dut_vec() !== exp_v) begin
      miscompares++;
      $display("FAIL reset_mid got %h expected %h", dut_vec(), exp_v);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      kbd_valid      = ($urandom_range(0, 1) == 1);
      kbd_data       = 8'($urandom);
      inp_ack        = ($urandom_range(0, 2) == 0);
      out_load       = ($urandom_range(0, 1) == 1);
      out_indata     = 8'($urandom);
      disp_ready     = ($urandom_range(0, 2) == 0);
      ion            = ($urandom_range(0, 5) == 0);
      iof            = ($urandom_range(0, 7) == 0);
      instr_boundary = ($urandom_range(0, 3) == 0);
      int_ack        = ($urandom_range(0, 5) == 0);
`ifdef IO_ERR_EN
      err_clr        = ($urandom_range(0, 9) == 0);
`endif
      tick();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random_%0d got %h expected %h", n, dut_vec(), model_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_input_fifo();
    test_output_fifo();
    test_interrupt();
    test_ien_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
